// File: rtl/elm_hidden_neuron_mac.sv
// Hidden-layer neuron datapath: weight fetch, saturating Q-format MAC, bias add, activation.
// Define ELM_RELU_EN to apply ReLU to the result; otherwise the activation is identity.
module elm_hidden_neuron_mac #(
    parameter int unsigned dataWidth    = 16,
    parameter int unsigned fracBits     = 8,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned numWeight    = 784
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [dataWidth-1:0]    myinput,
    input  logic                    myinputValid,
    input  logic [dataWidth-1:0]    bias,
    output logic                    ren,
    output logic [addressWidth:0]   raddr,
    input  logic [dataWidth-1:0]    wout,
    output logic [dataWidth-1:0]    out,
    output logic                    outvalid
);

    localparam int unsigned AccW = 2 * dataWidth;

    localparam logic [addressWidth:0] LastIdx = (addressWidth + 1)'(numWeight - 1);

    localparam logic signed [AccW-1:0] AccMax = {1'b0, {(AccW - 1){1'b1}}};
    localparam logic signed [AccW-1:0] AccMin = {1'b1, {(AccW - 1){1'b0}}};

    localparam logic signed [AccW:0] OutMaxW =
        {{(AccW - dataWidth + 2){1'b0}}, {(dataWidth - 1){1'b1}}};
    localparam logic signed [AccW:0] OutMinW =
        {{(AccW - dataWidth + 2){1'b1}}, {(dataWidth - 1){1'b0}}};

    logic [addressWidth:0]          addr_q;
    logic [addressWidth:0]          cnt_q;
    logic signed [dataWidth-1:0]    in_q;
    logic                           in_valid_q;
    logic signed [AccW-1:0]         prod_q;
    logic                           prod_valid_q;
    logic signed [AccW-1:0]         acc_q;
    logic signed [AccW-1:0]         final_q;
    logic                           final_valid_q;
    logic [dataWidth-1:0]           out_q;
    logic                           outvalid_q;

    logic signed [AccW-1:0]         prod_full;
    logic signed [AccW-1:0]         prod_shift;
    logic signed [AccW:0]           acc_sum;
    logic signed [AccW-1:0]         acc_sat;
    logic signed [AccW:0]           biased;
    logic signed [dataWidth-1:0]    biased_sat;
    logic [dataWidth-1:0]           act;

    assign ren      = myinputValid;
    assign raddr    = addr_q;
    assign out      = out_q;
    assign outvalid = outvalid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q <= '0;
        end else if (myinputValid) begin
            addr_q <= (addr_q == LastIdx) ? '0 : addr_q + 1'b1;
        end
    end

    // The delayed input lines up with wout, which arrives one cycle after ren.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_q       <= '0;
            in_valid_q <= 1'b0;
        end else begin
            in_q       <= $signed(myinput);
            in_valid_q <= myinputValid;
        end
    end

    always_comb begin
        prod_full  = AccW'(in_q) * AccW'($signed(wout));
        prod_shift = prod_full >>> fracBits;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
        end else begin
            prod_q       <= prod_shift;
            prod_valid_q <= in_valid_q;
        end
    end

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    always_comb begin
        acc_sum = (AccW + 1)'(acc_q) + (AccW + 1)'(prod_q);
        if (acc_sum[AccW] != acc_sum[AccW-1]) begin
            acc_sat = acc_sum[AccW] ? AccMin : AccMax;
        end else begin
            acc_sat = acc_sum[AccW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            final_q       <= '0;
            final_valid_q <= 1'b0;
        end else begin
            final_valid_q <= 1'b0;
            if (prod_valid_q) begin
                if (cnt_q == LastIdx) begin
                    final_q       <= acc_sat;
                    final_valid_q <= 1'b1;
                    acc_q         <= '0;
                    cnt_q         <= '0;
                end else begin
                    acc_q <= acc_sat;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        biased = (AccW + 1)'(final_q) + (AccW + 1)'($signed(bias));
        if (biased > OutMaxW) begin
            biased_sat = OutMaxW[dataWidth-1:0];
        end else if (biased < OutMinW) begin
            biased_sat = OutMinW[dataWidth-1:0];
        end else begin
            biased_sat = biased[dataWidth-1:0];
        end
`ifdef ELM_RELU_EN
        act = biased_sat[dataWidth-1] ? '0 : biased_sat;
`else
        act = biased_sat;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q      <= '0;
            outvalid_q <= 1'b0;
        end else begin
            outvalid_q <= final_valid_q;
            if (final_valid_q) begin
                out_q <= act;
            end
        end
    end

endmodule

// File: tb/tb_elm_hidden_neuron_mac.sv
// Directed bench for elm_hidden_neuron_mac with numWeight=4 and a registered-read weight memory.
module tb_elm_hidden_neuron_mac;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] myinput = '0;
    logic          myinputValid = 1'b0;
    logic [DW-1:0] bias = '0;
    logic          ren;
    logic [AW:0]   raddr;
    logic [DW-1:0] wout = '0;
    logic [DW-1:0] out;
    logic          outvalid;

    logic [DW-1:0] wmem [0:(2**(AW+1))-1];

    int            pass_cnt = 0;
    int            fail_cnt = 0;
    int            total = 0;
    logic          ov_s;
    logic [DW-1:0] out_s;
    logic [DW-1:0] exp_neg;
    logic [DW-1:0] exp_min;

    elm_hidden_neuron_mac #(
        .dataWidth    (16),
        .fracBits     (8),
        .addressWidth (AW),
        .numWeight    (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .myinput      (myinput),
        .myinputValid (myinputValid),
        .bias         (bias),
        .ren          (ren),
        .raddr        (raddr),
        .wout         (wout),
        .out          (out),
        .outvalid     (outvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) wout <= wmem[raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [DW-1:0] w);
        for (int i = 0; i < 4; i++) wmem[i] = w;
    endtask

    // Samples registered outputs at the negedge, then drives this cycle's input.
    task automatic tick(input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        ov_s = outvalid;
        out_s = out;
        myinputValid = v;
        myinput = d;
        #1;
    endtask

    task automatic send_pass(input string tag, input logic [DW-1:0] x);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, x);
            chk({tag, "_raddr"}, 32'(raddr), i);
            chk({tag, "_ren"}, 32'(ren), 1);
        end
    endtask

    task automatic expect_result(input string tag, input logic [DW-1:0] exp);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, '0);
            if (k < 4) begin
                chk({tag, "_early_ov"}, 32'(ov_s), 0);
            end else begin
                chk({tag, "_ov"}, 32'(ov_s), 1);
                chk({tag, "_out"}, 32'(out_s), 32'(exp));
            end
        end
        tick(1'b0, '0);
        chk({tag, "_ov_pulse"}, 32'(ov_s), 0);
        chk({tag, "_out_hold"}, 32'(out_s), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < 2**(AW+1); i++) wmem[i] = '0;
`ifdef ELM_RELU_EN
        exp_neg = 16'h0000;
        exp_min = 16'h0000;
`else
        exp_neg = 16'hFC00;
        exp_min = 16'h8000;
`endif

        #12;
        chk("rst_outvalid", 32'(outvalid), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_ren", 32'(ren), 0);
        @(negedge clk);
        rstn = 1'b1;

        // 1.0 * 1.0 four times
        fill(16'h0100);
        bias = 16'h0000;
        send_pass("s1", 16'h0100);
        expect_result("s1", 16'h0400);

        // positive overflow clamps to max
        fill(16'h7FFF);
        bias = 16'h7FFF;
        send_pass("s2a", 16'h7FFF);
        expect_result("s2a", 16'h7FFF);
        send_pass("s2b", 16'h8000);
        expect_result("s2b", exp_min);

        // negative result: identity or ReLU
        fill(16'hFF00);
        bias = 16'h0000;
        send_pass("s3", 16'h0100);
        expect_result("s3", exp_neg);

        // back-to-back passes, second with weight 0.5
        fill(16'h0100);
        send_pass("s4a", 16'h0100);
        tick(1'b1, 16'h0100);
        fill(16'h0080);
        chk("s4b_raddr0", 32'(raddr), 0);
        chk("s4b_ov_early", 32'(ov_s), 0);
        for (int i = 1; i < 4; i++) begin
            tick(1'b1, 16'h0100);
            chk("s4b_raddr", 32'(raddr), i);
            if (i < 3) chk("s4a_ov_early", 32'(ov_s), 0);
        end
        chk("s4a_ov", 32'(ov_s), 1);
        chk("s4a_out", 32'(out_s), 32'h0400);
        expect_result("s4b", 16'h0200);

        // bubbles between inputs
        fill(16'h0100);
        tick(1'b1, 16'h0100);
        chk("s5_raddr0", 32'(raddr), 0);
        tick(1'b0, 16'h1234);
        chk("s5_ren_bubble", 32'(ren), 0);
        tick(1'b0, 16'h0000);
        chk("s5_raddr_hold", 32'(raddr), 1);
        tick(1'b1, 16'h0100);
        chk("s5_raddr1", 32'(raddr), 1);
        tick(1'b0, 16'h0000);
        tick(1'b1, 16'h0100);
        chk("s5_raddr2", 32'(raddr), 2);
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);
        chk("s5_ov_gap", 32'(ov_s), 0);
        tick(1'b1, 16'h0100);
        chk("s5_raddr3", 32'(raddr), 3);
        expect_result("s5", 16'h0400);

        // reset mid-pass
        tick(1'b1, 16'h0100);
        tick(1'b1, 16'h0100);
        tick(1'b0, 16'h0000);
        rstn = 1'b0;
        #1;
        chk("s6_rst_raddr", 32'(raddr), 0);
        chk("s6_rst_ov", 32'(outvalid), 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 16'h0000);
            chk("s6_no_ov", 32'(ov_s), 0);
        end
        send_pass("s6", 16'h0100);
        expect_result("s6", 16'h0400);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/elm_hidden_neuron_mac.md
Name: elm_hidden_neuron_mac

Overview:
Per-neuron hidden-layer datapath for the ELM accelerator. It consumes a stream of input features and drives the read port of its neuron's weight memory, which has a one-cycle registered read. It forms the dot product in a saturating fixed-point accumulator, adds the bias and applies the activation. It emits one result per numWeight inputs and sits directly downstream of the per-neuron weight memory.

Parameters:
dataWidth, 16, signed fixed-point width of inputs, weights, bias and output
fracBits, 8, fractional bits of the shared Q format
addressWidth, 10, weight memory address width; raddr is addressWidth+1 bits
numWeight, 784, inputs per neuron pass; must be ≤ 2**addressWidth

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
myinput  input  dataWidth  signed input feature
myinputValid  input  1  myinput valid this cycle
bias  input  dataWidth  signed bias, Q format, static during a pass
ren  output  1  weight memory read enable
raddr  output  addressWidth+1  weight memory read address
wout  input  dataWidth  weight from memory, valid the cycle after ren
out  output  dataWidth  neuron result, signed Q format
outvalid  output  1  out valid, single-cycle pulse

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rstn.
- Reset values: outvalid=0, out=0, raddr=0, accumulator=0, input/product/final pipelines cleared, counters=0.
- Reset mid-pass discards all partial state; the next valid input is treated as index 0.
- Stage 0 (cycle t, myinputValid=1):
  - ren=myinputValid, combinational.
  - raddr = registered address counter.
  - Counter increments at the edge and wraps from numWeight-1 to 0.
- Stage 1 (edge ending t): myinput and valid registered into delay stage.
- Stage 2 (edge ending t+1):
  - product = delayed input × wout, signed, 2*dataWidth bits.
  - Arithmetic shift right by fracBits; held in 2*dataWidth bits.
- Stage 3 (edge ending t+2), when product valid:
  - Non-final product: acc = sat(acc + product) at signed 2*dataWidth limits; sample counter increments.
  - numWeight-th product: final_sum = sat(acc + product); acc loads 0; sample counter loads 0; final_valid=1.
- Stage 4 (edge ending t+3), when final_valid:
  - s = sat(final_sum + sign-extended bias); saturation clamps s to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
  - out = act(s); outvalid=1 for exactly one cycle.
  - out holds its value until the next result.
- Latency: last input at cycle L gives outvalid high at cycle L+4.
- Gaps: bubbles (myinputValid=0) between inputs are allowed; nothing advances except pipeline drain.
- Back-to-back: the next pass may start at L+1 with no corruption. The accumulator is cleared on the same edge that final_sum captures, so next-pass products land in a fresh accumulator.
- Overlap: simultaneous final accumulate and outvalid of the previous pass must both complete.
- Saturation is sticky per operation only; no overflow flag.

Optional Feature:
Macro ELM_RELU_EN.
- Defined: act(s) = (s < 0) ? 0 : s, i.e. ReLU.
- Undefined: act(s) = s, identity, so signed negative results pass through.
- Latency is identical in both builds.

Test Plan:
1. numWeight=4, inputs 0x0100 ×4, weights 0x0100 ×4, bias 0.
   - raddr=0,1,2,3 with ren high on each input cycle.
   - out=0x0400 with outvalid one cycle at L+4.
2. Inputs and weights all 0x7FFF, bias 0x7FFF → out=0x7FFF with no wrap. Repeat with input 0x8000 and weight 0x7FFF, no ReLU build → out=0x8000.
3. Inputs 0x0100, weights 0xFF00 (-1.0), bias 0.
   - Without ELM_RELU_EN: out=0xFC00.
   - With ELM_RELU_EN: out=0x0000.
4. Two passes back-to-back with no gap; pass1 as scenario 1, pass2 weights 0x0080 → out=0x0400 then out=0x0200, outvalid pulses four cycles apart. raddr sequence 0,1,2,3,0,1,2,3.
5. Random bubbles between the four inputs of scenario 1 → same out=0x0400, outvalid four cycles after the last valid input.
6. Assert rstn low after 2 of 4 inputs, release, then send 4 fresh inputs → no outvalid from the aborted pass, raddr restarts at 0, correct result from the fresh pass.
